// File: rtl/rs_pkg.sv
// rs_pkg: field and code constants shared by the RS(15,9) encoder and decoder.
//   GF(16) built on x^4 + x + 1 (alpha = 4'h2), symbols are 4 bits wide.
//   RS_ALOG[i] = alpha^i, RS_GEN[i] = g_i of g(x) = prod_{j=1..6} (x + alpha^j).
//   rs_state_e : encoder FSM states.
//   gf_mul     : GF(16) product, polynomial multiply reduced mod x^4 + x + 1.
package rs_pkg;

  localparam int unsigned RS_SYM_W = 4;
  localparam int unsigned RS_N     = 15;
  localparam int unsigned RS_K     = 9;
  localparam int unsigned RS_NPAR  = 6;

  // Low bits of the primitive polynomial: x^4 folds back to x + 1.
  localparam logic [3:0] RS_PRIM_POLY = 4'h3;

  localparam logic [3:0] RS_ALOG [0:14] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  localparam logic [3:0] RS_GEN [0:5] = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rs_state_e;

  // Shift-and-add multiply; with one constant operand this flattens to XORs.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] aa;
    acc = 4'h0;
    aa  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? RS_PRIM_POLY : 4'h0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mul4.sv
// gf_mul4: combinational GF(16) multiplier.
//   a_i [4] : operand (a constant generator coefficient in the encoder)
//   b_i [4] : operand
//   p_o [4] : a_i * b_i in GF(16)
module gf_mul4
  import rs_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] p_o
);

  assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/rs15_9_encoder.sv
// rs15_9_encoder: systematic RS(15,9) encoder, one message symbol per clock.
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   encodeMessage  : start request, sampled only in IDLE
//   messageIn [36] : message, symbol k at [4k+:4], latched on the accept edge
//   codeWordReady  : downstream accepts the codeword (used in DONE)
//   encoderBusy    : state != IDLE
//   codeWordValid  : state == DONE
//   codeWordOut[60]: {message, p5..p0}; only meaningful while codeWordValid
//
// state | meaning
// IDLE  | waiting for encodeMessage
// SHIFT | clocking message symbols 8..0 through the parity LFSR
// DONE  | codeword held until codeWordReady
module rs15_9_encoder
  import rs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        encodeMessage,
  input  logic [35:0] messageIn,
  input  logic        codeWordReady,
  output logic        encoderBusy,
  output logic        codeWordValid,
  output logic [59:0] codeWordOut
);

  rs_state_e        state_q, state_d;
  logic [35:0]      msg_q, msg_d;
  logic [5:0][3:0]  par_q, par_d;
  logic [5:0][3:0]  prod;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       sym;
  logic [3:0]       fb;

  assign sym = msg_q[{cnt_q, 2'b00} +: 4];
  assign fb  = sym ^ par_q[5];

  for (genvar g = 0; g < 6; g++) begin : g_mul
    gf_mul4 u_gf_mul4 (
      .a_i (RS_GEN[g]),
      .b_i (fb),
      .p_o (prod[g])
    );
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (encodeMessage) begin
          state_d = ST_SHIFT;
          msg_d   = messageIn;
          par_d   = '0;
          cnt_d   = 4'd8;
        end
      end
      ST_SHIFT: begin
        par_d[0] = prod[0];
        for (int i = 1; i < 6; i++) par_d[i] = par_q[i-1] ^ prod[i];
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: begin
        if (codeWordReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  assign encoderBusy   = (state_q != ST_IDLE);
  assign codeWordValid = (state_q == ST_DONE);
  assign codeWordOut   = {msg_q, par_q};

endmodule

// File: tb/tb_rs15_9_encoder.sv
// tb_rs15_9_encoder: randomized self-checking bench for rs15_9_encoder.
//   Reference: GF(16) via log/antilog tables, generator built as the product
//   of (x + alpha^j), parity by polynomial long division, plus a syndrome check.
module tb_rs15_9_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        encodeMessage = 1'b0;
  logic [35:0] messageIn = '0;
  logic        codeWordReady = 1'b0;
  logic        encoderBusy;
  logic        codeWordValid;
  logic [59:0] codeWordOut;

  int n_checks = 0;
  int n_fail   = 0;

  int         alog_t [0:14];
  int         log_t  [0:15];
  logic [3:0] gen_t  [0:6];

  always #5 clk = ~clk;

  rs15_9_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .encodeMessage (encodeMessage),
    .messageIn     (messageIn),
    .codeWordReady (codeWordReady),
    .encoderBusy   (encoderBusy),
    .codeWordValid (codeWordValid),
    .codeWordOut   (codeWordOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return 4'(alog_t[(log_t[a] + log_t[b]) % 15]);
  endfunction

  function automatic logic [59:0] ref_cw(input logic [35:0] m);
    logic [3:0]  r [0:14];
    logic [3:0]  c;
    logic [59:0] cw;
    for (int i = 0; i < 15; i++) r[i] = 4'h0;
    for (int k = 0; k < 9; k++) r[6+k] = m[4*k +: 4];
    for (int i = 14; i >= 6; i--) begin
      c = r[i];
      for (int j = 0; j <= 6; j++) r[i-6+j] = r[i-6+j] ^ fmul(c, gen_t[j]);
    end
    cw = '0;
    for (int i = 0; i < 6; i++) cw[4*i +: 4] = r[i];
    for (int k = 0; k < 9; k++) cw[4*(k+6) +: 4] = m[4*k +: 4];
    return cw;
  endfunction

  // Packs S1..S6 of a received word; zero for any valid codeword.
  function automatic logic [23:0] syndromes(input logic [59:0] cw);
    logic [23:0] s;
    logic [3:0]  acc;
    s = '0;
    for (int j = 1; j <= 6; j++) begin
      acc = 4'h0;
      for (int i = 0; i < 15; i++)
        acc = acc ^ fmul(cw[4*i +: 4], 4'(alog_t[(i*j) % 15]));
      s[4*(j-1) +: 4] = acc;
    end
    return s;
  endfunction

  task automatic build_tables();
    int v;
    logic [3:0] nxt [0:6];
    v = 1;
    for (int i = 0; i < 15; i++) begin
      alog_t[i] = v;
      log_t[v]  = i;
      v = v << 1;
      if (v & 16) v = (v ^ 16) ^ 3;
    end
    log_t[0] = 0;
    for (int i = 0; i <= 6; i++) gen_t[i] = 4'h0;
    gen_t[0] = 4'h1;
    for (int j = 1; j <= 6; j++) begin
      for (int i = 0; i <= 6; i++)
        nxt[i] = fmul(gen_t[i], 4'(alog_t[j])) ^ ((i > 0) ? gen_t[i-1] : 4'h0);
      for (int i = 0; i <= 6; i++) gen_t[i] = nxt[i];
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_encode(input logic [35:0] msg, input int hold, input bit start_at_e4,
                            input bit start_with_ready, input logic [59:0] exp_fixed,
                            input bit use_fixed);
    logic [59:0] exp_cw;
    logic [59:0] held;
    int lat;
    exp_cw = use_fixed ? exp_fixed : ref_cw(msg);
    messageIn = msg;
    encodeMessage = 1'b1;
    codeWordReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    encodeMessage = 1'b0;
    check("busy_after_accept", 64'(encoderBusy), 64'd1);
    check("valid_after_accept", 64'(codeWordValid), 64'd0);
    lat = 0;
    while (!codeWordValid && lat < 20) begin
      messageIn = {$urandom, $urandom};
      encodeMessage = start_at_e4 && (lat == 3);
      @(posedge clk);
      lat++;
      @(negedge clk);
      encodeMessage = 1'b0;
    end
    check("latency", 64'(lat), 64'd9);
    if (!codeWordValid) return;
    check("codeword", 64'(codeWordOut), 64'(exp_cw));
    check("syndromes", 64'(syndromes(codeWordOut)), 64'd0);
    held = codeWordOut;
    for (int c = 0; c < hold; c++) begin
      encodeMessage = $urandom_range(1, 0);
      messageIn = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      if (c == hold - 1 || (c % 5) == 0) begin
        check("bp_valid", 64'(codeWordValid), 64'd1);
        check("bp_cw", 64'(codeWordOut), 64'(held));
      end
    end
    codeWordReady = 1'b1;
    encodeMessage = start_with_ready;
    @(posedge clk);
    @(negedge clk);
    codeWordReady = 1'b0;
    encodeMessage = 1'b0;
    check("idle_busy", 64'(encoderBusy), 64'd0);
    check("idle_valid", 64'(codeWordValid), 64'd0);
    if (start_with_ready) begin
      @(posedge clk);
      @(negedge clk);
      check("no_start_on_ready", 64'(encoderBusy), 64'd0);
    end
  endtask

  initial begin
    build_tables();

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      encodeMessage = $urandom_range(1, 0);
      codeWordReady = $urandom_range(1, 0);
      messageIn = {$urandom, $urandom};
      @(negedge clk);
      check("rst_busy", 64'(encoderBusy), 64'd0);
      check("rst_valid", 64'(codeWordValid), 64'd0);
      check("rst_cw", 64'(codeWordOut), 64'd0);
    end
    encodeMessage = 1'b0;
    codeWordReady = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_stays_busy", 64'(encoderBusy), 64'd0);
    check("idle_stays_valid", 64'(codeWordValid), 64'd0);
    check("idle_stays_cw", 64'(codeWordOut), 64'd0);

    run_encode(36'h000000001, 0, 1'b0, 1'b0, 60'h000000001793CAC, 1'b1);
    run_encode(36'h000000002, 0, 1'b0, 1'b0, 60'h000000002E16B7B, 1'b1);
    run_encode(36'h000000000, 2, 1'b0, 1'b0, 60'h0, 1'b1);
    run_encode(36'h123456789, 20, 1'b0, 1'b1, 60'h0, 1'b0);
    run_encode(36'hFEDCBA987, 1, 1'b1, 1'b0, 60'h0, 1'b0);

    // Reset right after E5 must clear everything asynchronously.
    messageIn = 36'h0ABCDEF12;
    encodeMessage = 1'b1;
    @(posedge clk);
    @(negedge clk);
    encodeMessage = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(encoderBusy), 64'd0);
    check("midrst_valid", 64'(codeWordValid), 64'd0);
    check("midrst_cw", 64'(codeWordOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_encode(36'h000000001, 0, 1'b0, 1'b0, 60'h000000001793CAC, 1'b1);

    for (int n = 0; n < 200; n++) begin
      run_encode({$urandom, $urandom}, $urandom_range(3, 0), n % 7 == 3, n % 5 == 1,
                 60'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rs15_9_encoder.md
# rs15_9_encoder

Systematic Reed-Solomon RS(15,9) encoder over GF(16) (primitive polynomial x^4+x+1, α = 4'h2). It sits directly upstream of the RS(15,9) decoder. It takes a 36-bit message of nine 4-bit symbols and computes six parity symbols with a 6-stage LFSR, one message symbol per clock. It then presents a packed 60-bit codeword in exactly the layout the decoder unpacks. The generator polynomial has roots α^1..α^6, matching the decoder's syndromes S1..S6.

## Interface
Parameters: none. The code is fixed at n=15, k=9, t=3, with 4-bit symbols.

- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `encodeMessage`  in  1  start request; sampled only in IDLE
- `messageIn`  in  36  message; symbol k (k=0..8) at bits [4k+:4]
- `codeWordReady`  in  1  downstream accepts the codeword
- `encoderBusy`  out  1  high whenever state ≠ IDLE
- `codeWordValid`  out  1  high in DONE only
- `codeWordOut`  out  60  symbol i at bits [4i+:4]; symbols 0..5 are parity, symbols 6..14 are message symbols 0..8

## Operation
- Generator polynomial: g(x) = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C (hex). Coefficients g0..g5 = C, A, C, 3, 9, 7.
- Codeword: c(x) = m(x)·x^6 + (m(x)·x^6 mod g(x)), where m(x) = Σ m_k x^k.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when `encodeMessage`=1. On that edge, latch `messageIn` into msgReg, clear parity regs p0..p5 to 0, and set symCnt=8.
  - SHIFT: each cycle, feed symbol m_symCnt, so symbols go in order 8 down to 0.
    - f = m_symCnt ^ p5
    - p5←p4^g5·f, p4←p3^g4·f, p3←p2^g3·f, p2←p1^g2·f, p1←p0^g1·f, p0←g0·f
    - Decrement symCnt. When symCnt=0 is processed, go to DONE.
  - DONE: hold. When `codeWordReady`=1, go to IDLE.
- Output packing: `codeWordOut` = {msgReg, p5, p4, p3, p2, p1, p0}. It is driven continuously from registers and is stable for the whole of DONE.
- GF multiply is polynomial multiply mod x^4+x+1. Multiplication by a constant reduces to XOR networks. No carries anywhere; all addition is XOR.
- Boundary conditions:
  - `encodeMessage` in SHIFT or DONE is ignored; no queuing. It must be re-presented in IDLE.
  - `encodeMessage` and `codeWordReady` high together in DONE: the codeword completes and the FSM returns to IDLE. The start is not accepted on that edge.
  - `messageIn` is sampled only on the accept edge; later changes have no effect.
  - An all-zero message produces an all-zero codeword.
  - `rst_n` low at any time (including mid-SHIFT or DONE) immediately forces IDLE. All outputs and registers go to 0 and the in-flight codeword is discarded.

## Timing
- Reset values: `encoderBusy`=0, `codeWordValid`=0, `codeWordOut`=60'h0, state=IDLE, symCnt=0.
- The accept edge E0 is the edge where `encodeMessage` is sampled high in IDLE. `encoderBusy` goes high after E0.
- Edges E1..E9 perform the nine LFSR shifts. `codeWordValid` goes high after E9, so latency is 9 clocks from accept to valid.
- Valid and codeword are held under backpressure for any number of cycles.
- The codeword is accepted on the first edge where `codeWordValid` & `codeWordReady` are both 1. `encoderBusy` and `codeWordValid` drop after that edge.
- Minimum start-to-start period is 11 cycles: the earliest next accept is the edge after the IDLE return.
- During SHIFT, `codeWordOut` shows partial parity. Consumers must qualify it with `codeWordValid`.

## Structure
- Shared package `rs_pkg` holds:
  - symbol width 4, N=15, K=9, NPAR=6
  - primitive polynomial 4'h3 (x^4 = x+1)
  - the α^0..α^14 antilog table
  - generator coefficients `RS_GEN[0:5]` = C, A, C, 3, 9, 7
  - the FSM state enum
  - a `gf_mul` function
- The decoder uses the same package for its field constants.
- One sub-module, `gf_mul4`: a combinational 4×4 GF(16) multiplier. It is instantiated six times, once per generator coefficient with f as the variable operand. Synthesis folds the constants.

## Test plan
- Reset then idle: `rst_n`=0 with random inputs → all outputs 0. After release with no start, they stay 0.
- Unit message: `messageIn`=36'h000000001, pulse start → after 9 clocks `codeWordValid`=1, `codeWordOut`=60'h000000001793CAC.
- Scaled message: `messageIn`=36'h000000002 → `codeWordOut`=60'h000000002E16B7B. Loop 500 random messages into the decoder with ≤3 injected symbol errors; decoder `messageRecieved` must equal `messageIn`.
- Backpressure: hold `codeWordReady`=0 for 20 cycles in DONE → valid and codeword stay constant, `encodeMessage` pulses are ignored. Set ready=1 → IDLE next edge; the next start is accepted one cycle later.
- Start while busy: pulse `encodeMessage` with a new message at E4 → ignored; the output is still the first message's codeword.
- Reset mid-encode: assert `rst_n`=0 at E5 → outputs 0 immediately. After release, a fresh 36'h000000001 encode yields 60'h000000001793CAC.
